// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round scheduler.
// Holds the FSM encoding, the enable bundle and the round-constant table.
package aes_pkg;

  localparam int NB = 16;
  localparam int NR = 10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_ARK0,
    S_KEXP,
    S_SUB,
    S_SHIFT,
    S_MIX,
    S_ARK,
    S_OUT
  } state_e;

  typedef struct packed {
    logic ark;
    logic sb;
    logic sr;
    logic mc;
    logic ke;
  } en_t;

  function automatic logic [7:0] rcon_lut(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic en_t en_of(input state_e s);
    en_t e;
    e = '0;
    unique case (1'b1)
      (s == S_ARK0),
      (s == S_ARK):   e.ark = 1'b1;
      (s == S_SUB):   e.sb  = 1'b1;
      (s == S_SHIFT): e.sr  = 1'b1;
      (s == S_MIX):   e.mc  = 1'b1;
      (s == S_KEXP):  e.ke  = 1'b1;
      default:        e     = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant lookup: round number in, AES rcon byte out.
// Purely combinational; round 0 and out-of-range rounds give 00.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic [3:0] round,
  output logic [7:0] rcon
);

  assign rcon = rcon_lut(round);

endmodule

// File: rtl/aes_round_scheduler.sv
// Control FSM sequencing a byte-serial AES-128 datapath:
// load, initial AddRoundKey, NR rounds of step enables, then unload.
module aes_round_scheduler #(
  parameter int NR = aes_pkg::NR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] key_byte,
  input  logic [7:0] data_byte,
  output logic       in_ready,
  output logic       ark_en,
  output logic       sb_en,
  output logic       sr_en,
  output logic       mc_en,
  output logic       ke_en,
  output logic [3:0] byte_idx,
  output logic [3:0] round,
  output logic [7:0] rcon,
  output logic       load_en,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  import aes_pkg::*;

  localparam logic [3:0] LAST  = 4'(NB - 1);
  localparam logic [3:0] KLAST = 4'd3;
  localparam logic [3:0] RLAST = 4'(NR);

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] round_q, round_d;
  en_t        en_q;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       busy_q;
  logic       done_q, done_d;
  logic       phase_end;

  // key/data bytes are consumed by the datapath; only the handshake matters here
  logic [15:0] unused_bytes;
  assign unused_bytes = {key_byte, data_byte};

  assign phase_end = (idx_q == LAST);
  assign load_en   = in_valid & in_ready_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    round_d = round_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          round_d = '0;
        end
      end
      S_LOAD: begin
        if (load_en) begin
          idx_d = idx_q + 4'd1;
          if (phase_end) state_d = S_ARK0;
        end
      end
      S_ARK0: begin
        idx_d = idx_q + 4'd1;
        if (phase_end) begin
          state_d = S_KEXP;
          round_d = round_q + 4'd1;
        end
      end
      S_KEXP: begin
        if (idx_q == KLAST) begin
          idx_d   = '0;
          state_d = S_SUB;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_SUB: begin
        idx_d = idx_q + 4'd1;
        if (phase_end) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        idx_d = idx_q + 4'd1;
        // the final round has no MixColumns
        if (phase_end)
          state_d = (round_q == RLAST) ? S_ARK : S_MIX;
      end
      S_MIX: begin
        idx_d = idx_q + 4'd1;
        if (phase_end) state_d = S_ARK;
      end
      S_ARK: begin
        idx_d = idx_q + 4'd1;
        if (phase_end) begin
          if (round_q == RLAST) begin
            state_d = S_OUT;
          end else begin
            state_d = S_KEXP;
            round_d = round_q + 4'd1;
          end
        end
      end
      S_OUT: begin
        if (out_valid_q && out_ready) begin
          idx_d = idx_q + 4'd1;
          if (phase_end) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      round_q     <= '0;
      en_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      round_q     <= round_d;
      en_q        <= en_of(state_d);
      in_ready_q  <= (state_d == S_LOAD);
      out_valid_q <= (state_d == S_OUT);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= done_d;
    end
  end

  aes_rcon_gen u_rcon (
    .round (round_q),
    .rcon  (rcon)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign byte_idx  = idx_q;
  assign round     = round_q;
  assign ark_en    = en_q.ark;
  assign sb_en     = en_q.sb;
  assign sr_en     = en_q.sr;
  assign mc_en     = en_q.mc;
  assign ke_en     = en_q.ke;

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Bench for aes_round_scheduler: a behavioural AES datapath follows the
// enables, a scoreboard checks the unloaded ciphertext and the step trace.
module tb_aes_round_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] key_byte;
  logic [7:0] data_byte;
  logic       in_ready;
  logic       ark_en, sb_en, sr_en, mc_en, ke_en;
  logic [3:0] byte_idx;
  logic [3:0] round;
  logic [7:0] rcon;
  logic       load_en;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  aes_round_scheduler #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .key_byte  (key_byte),
    .data_byte (data_byte),
    .in_ready  (in_ready),
    .ark_en    (ark_en),
    .sb_en     (sb_en),
    .sr_en     (sr_en),
    .mc_en     (mc_en),
    .ke_en     (ke_en),
    .byte_idx  (byte_idx),
    .round     (round),
    .rcon      (rcon),
    .load_en   (load_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  localparam logic [2047:0] SBOX_P = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  int n_chk = 0;
  int n_fail = 0;

  function automatic void check(input string name, input int act,
                                input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp,
               $time);
    end
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_P[2047 - 8 * int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // behavioural byte-serial datapath driven by the scheduler enables
  logic [7:0] st [16];
  logic [7:0] rk [16];

  always @(negedge clk) begin : model
    logic [7:0] t [16];
    logic [7:0] w [4];
    logic [7:0] a0, a1, a2, a3;
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        st[i] = 8'h00;
        rk[i] = 8'h00;
      end
    end else begin
      if (load_en) begin
        st[byte_idx] = data_byte;
        rk[byte_idx] = key_byte;
      end
      if (ark_en) st[byte_idx] = st[byte_idx] ^ rk[byte_idx];
      if (sb_en) st[byte_idx] = sbox(st[byte_idx]);
      if (sr_en && byte_idx == 4'd15) begin
        t = st;
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            st[r + 4 * c] = t[r + 4 * ((c + r) % 4)];
      end
      if (mc_en && byte_idx == 4'd15) begin
        t = st;
        for (int c = 0; c < 4; c++) begin
          a0 = t[4 * c];
          a1 = t[4 * c + 1];
          a2 = t[4 * c + 2];
          a3 = t[4 * c + 3];
          st[4 * c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          st[4 * c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          st[4 * c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          st[4 * c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      if (ke_en && byte_idx == 4'd3) begin
        w[0] = sbox(rk[13]) ^ rcon;
        w[1] = sbox(rk[14]);
        w[2] = sbox(rk[15]);
        w[3] = sbox(rk[12]);
        for (int i = 0; i < 16; i++)
          rk[i] = rk[i] ^ ((i < 4) ? w[i] : rk[i - 4]);
      end
    end
  end

  // step-trace recorder: run-length of each enable, rcon and latency
  logic [4:0] cur = '0;
  int run_len = 0;
  int runs [$];
  logic [7:0] rc_q [$];
  int idx_err = 0;
  int oh_err = 0;
  int lcnt = 0;
  int cyc = 0;
  int t_load = 0;
  int t_out = 0;
  bit t_out_v = 1'b0;
  int done_cnt = 0;

  function automatic void check_block();
    int exp_r [$];
    int mism = 0;
    logic [7:0] rc_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    exp_r.push_back(16 * 256 + 16);
    for (int r = 1; r <= 10; r++) begin
      exp_r.push_back(1 * 256 + 4);
      exp_r.push_back(8 * 256 + 16);
      exp_r.push_back(4 * 256 + 16);
      if (r < 10) exp_r.push_back(2 * 256 + 16);
      exp_r.push_back(16 * 256 + 16);
    end
    check("trace_len", runs.size(), exp_r.size());
    for (int i = 0; i < exp_r.size(); i++)
      if (i >= runs.size() || runs[i] != exp_r[i]) mism++;
    check("trace_runs", mism, 0);
    check("byte_idx_seq", idx_err, 0);
    check("enable_onehot", oh_err, 0);
    check("rcon_count", rc_q.size(), 10);
    mism = 0;
    for (int i = 0; i < 10; i++)
      if (i >= rc_q.size() || rc_q[i] != rc_exp[i]) mism++;
    check("rcon_seq", mism, 0);
    // the load handshake edge follows the negedge where it was sampled
    check("latency", t_out - t_load - 1, 680);
    runs.delete();
    rc_q.delete();
    idx_err = 0;
    oh_err = 0;
  endfunction

  always @(negedge clk) begin : trace
    logic [4:0] code;
    cyc++;
    if (!rst) begin
      runs.delete();
      rc_q.delete();
      cur = '0;
      run_len = 0;
      idx_err = 0;
      oh_err = 0;
      lcnt = 0;
      t_out_v = 1'b0;
    end else begin
      code = {ark_en, sb_en, sr_en, mc_en, ke_en};
      if ($countones(code) > 1 ||
          (code != 5'd0 && (in_ready || out_valid || !busy)))
        oh_err++;
      if (code != cur) begin
        if (cur != 5'd0) runs.push_back(int'(cur) * 256 + run_len);
        cur = code;
        run_len = 0;
      end
      if (code != 5'd0) begin
        if (byte_idx != 4'(run_len)) idx_err++;
        run_len++;
      end
      if (ke_en && byte_idx == 4'd0) rc_q.push_back(rcon);
      if (load_en) begin
        if (lcnt == 15) begin
          t_load = cyc;
          t_out_v = 1'b0;
          lcnt = 0;
        end else begin
          lcnt++;
        end
      end
      if (out_valid && !t_out_v) begin
        t_out = cyc;
        t_out_v = 1'b1;
      end
      if (done) begin
        done_cnt++;
        check_block();
      end
    end
  end

  // scoreboard monitor on the output handshake
  logic [7:0] sb_q [$];
  bit hold_v = 1'b0;
  logic [3:0] hold_idx = '0;
  int opos = 0;

  always @(negedge clk) begin : monitor
    logic [7:0] exp_b;
    if (!rst) begin
      hold_v = 1'b0;
      opos = 0;
    end else begin
      if (hold_v)
        check("out_hold", int'({out_valid, byte_idx}),
              int'({1'b1, hold_idx}));
      hold_v = out_valid && !out_ready;
      hold_idx = byte_idx;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          exp_b = sb_q.pop_front();
          check("ct_byte", int'(st[byte_idx]), int'(exp_b));
          check("out_pos", int'(byte_idx), opos);
        end
        opos = (opos + 1) % 16;
      end
    end
  end

  function automatic int out_vec();
    return int'({in_ready, load_en, ark_en, sb_en, sr_en, mc_en, ke_en,
                 out_valid, busy, done, round, byte_idx, rcon});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vector(input bit gap);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      key_byte = KEY[127 - 8 * i -: 8];
      data_byte = PT[127 - 8 * i -: 8];
      tick();
      if (gap && i == 5) begin
        in_valid = 1'b0;
        repeat (3) tick();
        check("load_stall_ready", int'(in_ready), 1);
      end
    end
    in_valid = 1'b0;
    check("load_exit", int'({in_ready, ark_en}), 1);
  endtask

  task automatic run_block(input bit do_start, input bit gap,
                           input bit stall, input bit poke_r4,
                           input bit chain);
    int n;
    int cnt;
    bit hs;
    bit stalled;
    for (int i = 0; i < 16; i++) sb_q.push_back(CT[127 - 8 * i -: 8]);
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    check("load_entry", int'(in_ready), 1);
    load_vector(gap);
    if (poke_r4) begin
      n = 0;
      while (round != 4'd4 && n < 2000) begin
        tick();
        n++;
      end
      check("reach_round4", int'(round), 4);
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    n = 0;
    while (!out_valid && n < 2000) begin
      tick();
      n++;
    end
    check("out_valid_wait", int'(out_valid), 1);
    out_ready = 1'b1;
    n = 0;
    cnt = 0;
    stalled = 1'b0;
    while (cnt < 16 && n < 200) begin
      hs = out_valid && out_ready;
      tick();
      n++;
      if (hs) cnt++;
      if (stall && cnt == 8 && !stalled) begin
        stalled = 1'b1;
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
      end
    end
    check("out_count", cnt, 16);
    check("done_pulse", int'({done, busy}), 2);
    if (chain) start = 1'b1;
    tick();
    start = 1'b0;
    check("done_once", int'(done), 0);
    if (chain) check("start_in_done", int'(in_ready), 1);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    key_byte = 8'h00;
    data_byte = 8'h00;
    out_ready = 1'b1;
    #12;
    check("reset_state", out_vec(), 0);
    start = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    tick();
    start = 1'b0;
    check("first_start", int'({in_ready, busy}), 3);

    // gaps, stall, ignored start in round 4, start in the done cycle
    run_block(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    // chained block already in LOAD
    run_block(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // abort mid-round with reset
    for (int i = 0; i < 16; i++) sb_q.push_back(CT[127 - 8 * i -: 8]);
    start = 1'b1;
    tick();
    start = 1'b0;
    load_vector(1'b0);
    n = 0;
    while (!(round == 4'd6 && mc_en && byte_idx == 4'd9) && n < 3000) begin
      tick();
      n++;
    end
    check("reach_r6_mix9", int'({round, mc_en, byte_idx}),
          int'({4'd6, 1'b1, 4'd9}));
    rst = 1'b0;
    #1;
    check("reset_async", out_vec(), 0);
    sb_q.delete();
    @(negedge clk);
    tick();
    check("reset_hold", out_vec(), 0);
    rst = 1'b1;
    run_block(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    check("done_total", done_cnt, 3);
    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_round_scheduler.md
AES_ROUND_SCHEDULER -- requirements
Module: aes_round_scheduler

Interface
REQ-001 SHALL have parameter NR, default 10, meaning number of AES-128 rounds; only 10 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request one block encryption; sampled only in IDLE.
REQ-005 SHALL have port in_valid  input  1  key_byte/data_byte valid.
REQ-006 SHALL have ports key_byte and data_byte  input  8 each  key byte and plaintext byte, sent MSB first (key[127:120] first).
REQ-007 SHALL have port in_ready  output  1  high only in LOAD.
REQ-008 SHALL have ports ark_en, sb_en, sr_en, mc_en, ke_en  output  1 each  one-hot datapath step enables (AddRoundKey, SubBytes, ShiftRows, MixColumns, key-expansion word step).
REQ-009 SHALL have port byte_idx  output  4  byte index within the current phase; word index 0..3 in KEXP.
REQ-010 SHALL have port round  output  4  current round, 0..10.
REQ-011 SHALL have port rcon  output  8  round constant for round (1..10: 01,02,04,08,10,20,40,80,1b,36); 00 when round=0.
REQ-012 SHALL have port load_en  output  1  high on each accepted input byte pair.
REQ-013 SHALL have ports out_valid  output  1  ciphertext byte valid, and out_ready  input  1.
REQ-014 SHALL have ports busy  output  1  high whenever state is not IDLE, and done  output  1  one-cycle pulse after the last output byte.

Function
REQ-015 SHALL implement states IDLE, LOAD, ARK0, KEXP, SUB, SHIFT, MIX, ARK, OUT.
REQ-016 SHALL move IDLE->LOAD on start=1, clearing the byte counter and setting round=0.
REQ-017 SHALL, in LOAD, accept a byte pair only when in_valid and in_ready are both high; gaps in in_valid stall without losing count; after the 16th handshake SHALL go to ARK0.
REQ-018 SHALL hold each of ARK0, SUB, SHIFT, MIX and ARK for exactly 16 cycles, with byte_idx 0..15, and assert the matching enable every cycle.
REQ-019 SHALL hold KEXP for exactly 4 cycles, with byte_idx 0..3 and ke_en high.
REQ-020 SHALL, at ARK0 exit and at ARK exit with round<10, increment round and enter KEXP.
REQ-021 SHALL sequence KEXP->SUB->SHIFT->MIX->ARK for rounds 1..9, and KEXP->SUB->SHIFT->ARK for round 10 (MIX skipped).
REQ-022 SHALL go ARK->OUT at round 10; compute latency from the 16th load handshake to the first out_valid cycle SHALL be 680 cycles.
REQ-023 SHALL, in OUT, advance byte_idx only on out_valid&out_ready; out_ready low holds byte_idx and out_valid.
REQ-024 SHALL go OUT->IDLE after the 16th output handshake and pulse done in the first IDLE cycle.
REQ-025 SHALL ignore start while busy; a start coincident with the done pulse SHALL be accepted.
REQ-026 SHALL keep all enables low in IDLE, LOAD and OUT, and never assert more than one enable per cycle.
REQ-027 SHALL wrap byte_idx 15->0 (3->0 in KEXP) on every phase change.

Reset
REQ-028 SHALL, on rst low at any time (including mid-round or mid-OUT), enter IDLE immediately with round=0, byte_idx=0, rcon=00, and in_ready, load_en, all enables, out_valid, busy and done at 0.
REQ-029 SHALL leave reset synchronously; the first start SHALL be honoured on the first rising edge with rst high.

Structure
REQ-030 SHALL take the state enumeration, NB=16, NR=10 and the rcon table from the shared package aes_pkg.
REQ-031 SHALL place the rcon lookup in the sub-module aes_rcon_gen (4-bit round in, 8-bit rcon out, combinational).

Verification
REQ-032 SHALL pass the FIPS-197 vector: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734, with a behavioural datapath model -> ciphertext 3925841d02dc09fbdc118597196a0b32, done pulses once.
REQ-033 SHALL check the enable trace: ARK0 for 16 cycles, then 9x(4 KEXP, 16 SUB, 16 SHIFT, 16 MIX, 16 ARK), then 4+16+16+16 for round 10, then out_valid at cycle 680; the rcon sequence SHALL be 01..36.
REQ-034 SHALL drop in_valid for 3 cycles after byte 5 and drop out_ready for 5 cycles after output byte 7 -> ciphertext unchanged, and byte_idx/out_valid held during the stall.
REQ-035 SHALL pulse start in round 4 -> ignored and trace unchanged; SHALL assert start in the done cycle -> LOAD entered on the next cycle.
REQ-036 SHALL assert rst low during round 6 MIX, byte_idx 9 -> all outputs 0 immediately; then re-run the vector -> correct ciphertext.
